// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- handshaked RV32I data-memory controller.
//
// Sits between the MEM stage / LSU and a word-organised data RAM with one
// request outstanding at a time. A request is captured in IDLE, the access
// is performed in a single COMMIT cycle exactly LATENCY cycles after the
// accept edge, and the registered response is held until rsp_ready.
//
// Optional build macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned lh/lhu/sh (addr[0]) and lw/sw (addr[1:0]) fault
//   undefined : misaligned low address bits are ignored
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address (ADDR_W bits)
//   req_wdata             right-aligned store data
//   req_funct3            RV32I load/store funct3
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data; 0 for stores and faults
//   rsp_fault             access rejected, no memory side effect
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [2:0]        cap_f3;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    // ---------------------------------------------------------------
    // Decode of the captured request
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] idx;
    logic             range_err, f3_err, align_err, fault;
    logic [31:0]      word, load_data, wr_data;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [3:0]       wr_be;

    assign idx = cap_addr[IDX_W+1:2];

    // Any address bit above the word index selects memory that isn't there.
    assign range_err = (cap_addr >> (IDX_W + 2)) != '0;

    always_comb begin
        f3_err = 1'b1;
        if (cap_we)
            f3_err = !(cap_f3 inside {3'b000, 3'b001, 3'b010});
        else
            f3_err = !(cap_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        align_err = 1'b0;
        case (cap_f3[1:0])
            2'b01:   align_err = cap_addr[0];
            2'b10:   align_err = |cap_addr[1:0];
            default: align_err = 1'b0;
        endcase
    end
`else
    assign align_err = 1'b0;
`endif

    assign fault = range_err | f3_err | align_err;

    // Load path: lane select then sign/zero extension.
    assign word     = mem[idx];
    assign sel_byte = word[8*cap_addr[1:0] +: 8];
    assign sel_half = cap_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        case (cap_f3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'h0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'h0, sel_half};
            3'b010:  load_data = word;
            default: load_data = '0;
        endcase
    end

    // Store path: replicate the datum across lanes, enable only the target.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = cap_wdata;
        case (cap_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << cap_addr[1:0];
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = cap_wdata;
            end
        endcase
    end

    // Memory is not reset. An async reset forces state to IDLE, so a
    // store that has not yet reached COMMIT can never be written.
    always_ff @(posedge clk) begin
        if (state == COMMIT && cap_we && !fault) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nx = COMMIT;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = COMMIT;
            end
            COMMIT: state_nx = RESP;
            RESP:   if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_f3    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_f3    <= req_funct3;
            end
            if (state == COMMIT) begin
                rsp_valid <= 1'b1;
                rsp_fault <= fault;
                rsp_rdata <= (fault || cap_we) ? 32'h0 : load_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_dmem_ctrl;

    localparam int DW  = 1024;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int checks = 0;
    int errors = 0;
    bit rnd = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(DW), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit mfault(input bit we, input logic [31:0] a, input logic [2:0] f3);
        bit legal;
        if (a >= 32'(DW * 4)) return 1'b1;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd4: return b;
            3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd5: return h;
            3'd2: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mstore(input logic [31:0] old, input logic [31:0] a,
                                           input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] mask;
        int sh;
        case (f3)
            3'd0: begin
                sh = 8 * a[1:0];
                mask = 32'hFF << sh;
                return (old & ~mask) | ((wd & 32'hFF) << sh);
            end
            3'd1: begin
                sh = a[1] ? 16 : 0;
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((wd & 32'hFFFF) << sh);
            end
            default: return wd;
        endcase
    endfunction

    logic [31:0] m_mem [0:DW-1];
    bit          m_busy, m_valid, m_fault, m_we;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [2:0]  m_f3;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_fault <= mfault(m_we, m_addr, m_f3);
                m_rdata <= (mfault(m_we, m_addr, m_f3) || m_we) ? 32'h0
                           : mload(m_mem[(m_addr / 4) % DW], m_addr, m_f3);
                if (m_we && !mfault(m_we, m_addr, m_f3))
                    m_mem[(m_addr / 4) % DW] <= mstore(m_mem[(m_addr / 4) % DW], m_addr, m_wdata, m_f3);
            end
            m_cnt <= m_cnt - 1;
        end else if (req_valid) begin
            m_busy  <= 1'b1;
            m_cnt   <= LAT;
            m_we    <= req_we;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
            m_f3    <= req_funct3;
        end
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_fault", 32'(rsp_fault), 32'(m_fault));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!m_busy && n < 50);
        if (!m_busy) check("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (!rsp_valid) check("rsp_timeout", 32'(lat), 32'd0);
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic flt);
        int lat, n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        wait_accept();
        wait_rsp(lat);
        check("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata; flt = rsp_fault;
        n = 0;
        do begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end while (m_busy && n < 100);
        if (m_busy) check("handshake_timeout", 32'(n), 32'd0);
    endtask

    logic [31:0] rd;
    logic        flt;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_fault", 32'(rsp_fault), 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 3'd2, rd, flt);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, flt);
        check("sw rdata", rd, 32'h0);
        check("sw fault", 32'(flt), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 3'd2, rd, flt);
        check("lw 0x10", rd, 32'hDEADBEEF);

        txn(1'b1, 32'h13, 32'h0000007F, 3'd0, rd, flt);
        txn(1'b0, 32'h13, 32'h0, 3'd0, rd, flt);
        check("lb 0x13", rd, 32'h0000007F);
        txn(1'b0, 32'h12, 32'h0, 3'd4, rd, flt);
        check("lbu 0x12", rd, 32'h000000AD);
        txn(1'b0, 32'h12, 32'h0, 3'd1, rd, flt);
        check("lh 0x12", rd, 32'h00007FAD);

        txn(1'b1, 32'h10, 32'h00008001, 3'd1, rd, flt);
        txn(1'b0, 32'h10, 32'h0, 3'd1, rd, flt);
        check("lh 0x10", rd, 32'hFFFF8001);
        txn(1'b0, 32'h10, 32'h0, 3'd5, rd, flt);
        check("lhu 0x10", rd, 32'h00008001);

        // Backpressure; a store offered while busy must be ignored.
        begin
            int lat;
            rsp_ready = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
            wait_accept();
            wait_rsp(lat);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'd2;
            for (int i = 0; i < 5; i++) begin
                check("bp rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp rsp_rdata", rsp_rdata, 32'h7FAD8001);
                check("bp req_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            check("bp resume req_ready", 32'(req_ready), 32'd1);
            check("bp rsp_valid clear", 32'(rsp_valid), 32'd0);
        end

        txn(1'b0, 32'(DW * 4), 32'h0, 3'd2, rd, flt);
        check("oob fault", 32'(flt), 32'd1);
        check("oob rdata", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 3'd3, rd, flt);
        check("bad f3 fault", 32'(flt), 32'd1);
        txn(1'b1, 32'h10, 32'h0, 3'd4, rd, flt);
        check("bad store f3 fault", 32'(flt), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 3'd2, rd, flt);
        check("mem unchanged", rd, 32'h7FAD8001);

        // Reset during WAIT drops the store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'd2;
        wait_accept();
        #2 rst_n = 1'b0;
        #1;
        check("mid reset req_ready", 32'(req_ready), 32'd1);
        check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid reset rsp_rdata", rsp_rdata, 32'd0);
        check("mid reset rsp_fault", 32'(rsp_fault), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        txn(1'b0, 32'h20, 32'h0, 3'd2, rd, flt);
        check("dropped store", rd, 32'hC0DE0008);

        txn(1'b0, 32'h22, 32'h0, 3'd2, rd, flt);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw 0x22 fault", 32'(flt), 32'd1);
        check("lw 0x22 rdata", rd, 32'h0);
`else
        check("lw 0x22 fault", 32'(flt), 32'd0);
        check("lw 0x22 rdata", rd, 32'hC0DE0008);
`endif

        // Randomized traffic against the model.
        rnd = 1'b1;
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? (32'(DW * 4) + $urandom_range(0, 4095))
                                             : 32'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(1'($urandom_range(0, 1)), a, $urandom(), 3'($urandom_range(0, 7)), rd, flt);
        end
        rnd = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
